// File: rtl/alarm_countdown_timer.sv
// Alarm countdown timer: loads one of four delays on start and counts it
// down in whole seconds using an internal free-running 1 Hz divider.
module alarm_countdown_timer #(
    parameter int CLK_HZ = 25_000_000,
    parameter int TIME_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [TIME_W-1:0] t_arm_delay,
    input  logic [TIME_W-1:0] t_driver_delay,
    input  logic [TIME_W-1:0] t_passenger_delay,
    input  logic [TIME_W-1:0] t_alarm_delay,
    input  logic [1:0]        interval_sel,
    input  logic              start_timer,
    output logic              running,
    output logic [TIME_W-1:0] remaining,
    output logic              expired,
    output logic              one_hz
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [DIV_W-1:0]  div;
    logic              tick;
    logic [TIME_W-1:0] load_val;
    logic [1:0]        state;

    // The second boundary is the last divider count, not the registered tick,
    // so a value N expires exactly N*CLK_HZ+1 cycles after its start.
    assign tick    = (div == DIV_LAST);
    assign running = (state == COUNT);

    // Pick the delay that a start strobe would load
    always_comb begin
        load_val = t_arm_delay;
        unique case (interval_sel)
            2'b00: load_val = t_arm_delay;
            2'b01: load_val = t_driver_delay;
            2'b10: load_val = t_passenger_delay;
            2'b11: load_val = t_alarm_delay;
        endcase
    end

    // Free-running divider; a start realigns it so the first second is full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            one_hz <= 1'b0;
        end else begin
            one_hz <= tick;
            if (start_timer || tick)
                div <= '0;
            else
                div <= div + DIV_W'(1);
        end
    end

    // Countdown FSM; a start always wins over the running count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            expired   <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (start_timer) begin
                remaining <= load_val;
                if (load_val == '0) begin
                    state   <= DONE;
                    expired <= 1'b1;
                end else begin
                    state <= COUNT;
                end
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    COUNT: begin
                        if (tick) begin
                            if (remaining <= TIME_W'(1)) begin
                                remaining <= '0;
                                state     <= DONE;
                                expired   <= 1'b1;
                            end else begin
                                remaining <= remaining - TIME_W'(1);
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
